conflict_monitor: RTL
=====================

// Module: conflict_monitor
// PURPOSE
//  Independent safety checker that observes the traffic_fsm lamp/walk outputs and
//  produces the latched system_fault input that the FSM consumes. Detects conflicting
//  greens, illegal lamp combinations, bad walk signals and timing violations (short
//  yellow, missing all-red clearance). Records the first cause in fault_code.
// PARAMETERS
//  FILTER_CYCLES  4  consecutive clk cycles a level violation must persist before it latches
//  MIN_YELLOW     3  minimum tick_1hz pulses a direction's yellow must span
//  MIN_ALLRED     1  minimum tick_1hz pulses of full all-red before any green onset
// PORTS
//  clk               in   1  system clock
//  rst               in   1  synchronous, active-high reset
//  tick_1hz          in   1  1-cycle 1Hz pulse from clk_div
//  ns_str_{green,yellow,red}, ns_left_{green,yellow,red}  in 1 each  N/S lamp drives
//  ew_str_{green,yellow,red}, ew_left_{green,yellow,red}  in 1 each  E/W lamp drives
//  ns_ped_walk, ew_ped_walk  in   1  walk drives
//  system_fault      out  1  latched fault; high until rst
//  fault_code        out  3  first cause: 0 none,1 conflict,2 ped,3 lamp,4 short yellow,5 no clearance
// BEHAVIOUR
//  One clock, single-cycle registered logic; reset is synchronous and active-high.
//  Reset: system_fault=0, fault_code=0, state=MONITOR, filter counters=0,
//   yellow counters=0, allred_cnt=MIN_ALLRED (saturated), history registers=0.
//  Derived per direction D: D_grn = str_g|left_g; D_yel = str_y|left_y;
//   D_red = str_r&left_r&!D_grn&!D_yel. all_red = ns_red & ew_red.
//  Level violations (each has its own filter counter):
//   conflict: (ns_grn & (ew_grn|ew_yel)) | (ew_grn & (ns_grn|ns_yel)).
//    Yellow+yellow on both directions is legal (emergency yellow).
//   ped: walk while own D_grn=0, or both walks high.
//   lamp: any of the 4 heads not exactly one-hot in {g,y,r}.
//   Counter increments each cycle the violation is present, clears to 0 the cycle it is
//   absent; the violation latches in the cycle the counter reaches FILTER_CYCLES-1
//   while still present. FILTER_CYCLES=1 means latch on first cycle.
//  Event violations (latch in the cycle detected, no filter):
//   short yellow: per D, yel_cnt clears on D_yel rising edge, +1 per tick while D_yel,
//    saturates at 15; on D_yel falling edge with yel_cnt<MIN_YELLOW -> violation.
//   no clearance: allred_cnt +1 per tick while all_red (sat 15), clears to 0 in any cycle
//    !all_red; on rising edge of ns_grn or ew_grn with allred_cnt<MIN_ALLRED -> violation.
//   Edges use 1-cycle history registers of D_grn/D_yel (reset 0). With allred_cnt reset
//   saturated, first green after reset is legal.
//  FSM: MONITOR -> FAULT when any violation latches; FAULT is absorbing until rst.
//   Entry to FAULT: system_fault=1 next cycle; fault_code = lowest-numbered code among
//   violations in that cycle (conflict highest priority).
//   In FAULT all checks, counters and fault_code are frozen (FSM blink pattern is
//   not checked).
//  Latency: event violation at cycle N -> system_fault high at N+1.
//  Reset mid-operation: asserting rst in FAULT clears everything the next edge; rst
//   dominates a violation in the same cycle.
//  tick_1hz coincident with an edge: rising-edge cycle counts the tick (yellow 1 tick
//   min); falling-edge cycle does not.
// TESTING
//  1 Normal NS/EW cycle (9s green, 5s yellow, 2s all-red) x3 -> system_fault stays 0.
//  2 Drive ns_str_green=1 & ew_str_green=1 for 3 clks, then 4 clks -> no fault after 3;
//    fault after 4th cycle, fault_code=1.
//  3 NS yellow lasting 2 ticks then red -> fault 1 cycle after yellow falls, code=4.
//  4 EW yellow->red then NS green in same cycle all-red begins (0 ticks) -> code=5;
//    reset-then-immediate NS green -> no fault.
//  5 Emergency pattern: both yellow 5s, all-red 2s, NS green -> no fault; ns_ped_walk
//    during EW green 4 clks -> code=2.
//  6 Conflict + lamp fault same cycle -> code=1; assert rst 1 clk -> fault 0, code 0.

Source files
------------

// File: rtl/conflict_monitor.sv
// Safety checker watching the intersection lamp and walk drives. It latches
// system_fault on the first illegal condition and records the first cause in fault_code.
module conflict_monitor #(
  parameter int FILTER_CYCLES = 4,
  parameter int MIN_YELLOW    = 3,
  parameter int MIN_ALLRED    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       ns_str_green,
  input  logic       ns_str_yellow,
  input  logic       ns_str_red,
  input  logic       ns_left_green,
  input  logic       ns_left_yellow,
  input  logic       ns_left_red,
  input  logic       ew_str_green,
  input  logic       ew_str_yellow,
  input  logic       ew_str_red,
  input  logic       ew_left_green,
  input  logic       ew_left_yellow,
  input  logic       ew_left_red,
  input  logic       ns_ped_walk,
  input  logic       ew_ped_walk,
  output logic       system_fault,
  output logic [2:0] fault_code
);

  // state   | meaning
  // MONITOR | all checks active, counters and history advancing
  // FAULT   | fault latched; checks, counters and fault_code frozen until rst

  typedef enum logic {MONITOR, FAULT} state_t;

  // The filter counter only ever has to reach FILTER_CYCLES-1.
  localparam int FW = (FILTER_CYCLES < 2) ? 1 : $clog2(FILTER_CYCLES);
  localparam logic [FW-1:0] FILT_TC = FW'(FILTER_CYCLES - 1);
  localparam logic [3:0]    MIN_Y   = 4'(MIN_YELLOW);
  localparam logic [3:0]    MIN_AR  = 4'(MIN_ALLRED);

  state_t        state;
  logic [FW-1:0] conf_cnt, ped_cnt, lamp_cnt;
  logic [3:0]    yel_cnt [2];
  logic [3:0]    allred_cnt;
  logic [1:0]    grn_q, yel_q;

  logic [1:0] d_grn, d_yel, d_red;
  logic       all_red, conf_now, ped_now, lamp_now;
  logic       conf_v, ped_v, lamp_v, short_v, clear_v;
  logic [1:0] yel_fall_short;
  logic [2:0] v_code;

  function automatic logic [3:0] sat_inc(input logic [3:0] c, input logic inc);
    return (c == 4'hF) ? c : c + {3'b000, inc};
  endfunction

  // Index 0 is north/south, index 1 is east/west.
  always_comb begin
    d_grn = {ew_str_green | ew_left_green, ns_str_green | ns_left_green};
    d_yel = {ew_str_yellow | ew_left_yellow, ns_str_yellow | ns_left_yellow};
    d_red[0] = ns_str_red & ns_left_red & ~d_grn[0] & ~d_yel[0];
    d_red[1] = ew_str_red & ew_left_red & ~d_grn[1] & ~d_yel[1];
    all_red  = d_red[0] & d_red[1];

    // Yellow on both directions at once is the legal emergency pattern.
    conf_now = (d_grn[0] & (d_grn[1] | d_yel[1])) | (d_grn[1] & (d_grn[0] | d_yel[0]));
    ped_now  = (ns_ped_walk & ~d_grn[0]) | (ew_ped_walk & ~d_grn[1]) |
               (ns_ped_walk & ew_ped_walk);
    lamp_now = ~($onehot({ns_str_green,  ns_str_yellow,  ns_str_red})  &
                 $onehot({ns_left_green, ns_left_yellow, ns_left_red}) &
                 $onehot({ew_str_green,  ew_str_yellow,  ew_str_red})  &
                 $onehot({ew_left_green, ew_left_yellow, ew_left_red}));

    conf_v = conf_now & (conf_cnt == FILT_TC);
    ped_v  = ped_now  & (ped_cnt  == FILT_TC);
    lamp_v = lamp_now & (lamp_cnt == FILT_TC);

    yel_fall_short[0] = yel_q[0] & ~d_yel[0] & (yel_cnt[0] < MIN_Y);
    yel_fall_short[1] = yel_q[1] & ~d_yel[1] & (yel_cnt[1] < MIN_Y);
    short_v = |yel_fall_short;
    clear_v = (|(d_grn & ~grn_q)) & (allred_cnt < MIN_AR);

    v_code = 3'd0;
    if (conf_v)       v_code = 3'd1;
    else if (ped_v)   v_code = 3'd2;
    else if (lamp_v)  v_code = 3'd3;
    else if (short_v) v_code = 3'd4;
    else if (clear_v) v_code = 3'd5;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= MONITOR;
      system_fault <= 1'b0;
      fault_code   <= 3'd0;
      conf_cnt     <= '0;
      ped_cnt      <= '0;
      lamp_cnt     <= '0;
      yel_cnt[0]   <= 4'd0;
      yel_cnt[1]   <= 4'd0;
      allred_cnt   <= MIN_AR;
      grn_q        <= 2'b00;
      yel_q        <= 2'b00;
    end else begin
      case (state)
        MONITOR: begin
          conf_cnt <= conf_now ? conf_cnt + 1'b1 : '0;
          ped_cnt  <= ped_now  ? ped_cnt  + 1'b1 : '0;
          lamp_cnt <= lamp_now ? lamp_cnt + 1'b1 : '0;
          // A tick in the yellow onset cycle counts toward the yellow span.
          for (int i = 0; i < 2; i++) begin
            if (d_yel[i] && !yel_q[i])
              yel_cnt[i] <= {3'b000, tick_1hz};
            else if (d_yel[i])
              yel_cnt[i] <= sat_inc(yel_cnt[i], tick_1hz);
          end
          allred_cnt <= all_red ? sat_inc(allred_cnt, tick_1hz) : 4'd0;
          grn_q      <= d_grn;
          yel_q      <= d_yel;
          if (v_code != 3'd0) begin
            state        <= FAULT;
            system_fault <= 1'b1;
            fault_code   <= v_code;
          end
        end
        default: begin
          state <= FAULT;
        end
      endcase
    end
  end

endmodule
